// File: rtl/aclk_controller_pkg.sv
// Shared definitions for the alarm-clock controller: key codes, state
// encodings, default timeout and the output bundle type.
package aclk_controller_pkg;

   localparam logic [3:0] NOKEY = 4'hA;

   localparam int unsigned TIMEOUT_SEC_DEF = 10;

   typedef enum logic [2:0] {
      SHOW_TIME        = 3'd0,
      KEY_STORED       = 3'd1,
      KEY_WAITED       = 3'd2,
      KEY_ENTRY        = 3'd3,
      SHOW_ALARM       = 3'd4,
      SET_ALARM_TIME   = 3'd5,
      SET_CURRENT_TIME = 3'd6
   } state_t;

   typedef struct packed {
      logic shift;
      logic load_new_a;
      logic load_new_c;
      logic show_new_time;
      logic show_a;
   } ctrl_out_t;

   // Codes 0-9 are digits; NOKEY and every other code mean "no key".
   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

endpackage

// File: rtl/aclk_controller_if.sv
// Keypad/button inputs and strobe/display outputs of the alarm-clock
// controller. master = controller side, slave = datapath side.
interface aclk_controller_if;

   logic       one_second;
   logic [3:0] key;
   logic       alarm_button;
   logic       time_button;

   logic       shift;
   logic       load_new_a;
   logic       load_new_c;
   logic       show_new_time;
   logic       show_a;

   modport master (
      input  one_second,
      input  key,
      input  alarm_button,
      input  time_button,
      output shift,
      output load_new_a,
      output load_new_c,
      output show_new_time,
      output show_a
   );

   modport slave (
      output one_second,
      output key,
      output alarm_button,
      output time_button,
      input  shift,
      input  load_new_a,
      input  load_new_c,
      input  show_new_time,
      input  show_a
   );

endinterface

// File: rtl/aclk_controller_timeout.sv
// Saturating seconds counter that flags key-entry inactivity.
module aclk_timeout
   import aclk_controller_pkg::*;
#(
   parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEF,
   parameter int unsigned CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic one_second,
   output logic timeout
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_SEC);

   logic [CNT_W-1:0] count;

   // Count seconds up to LIMIT; clear has priority over a coincident pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (one_second && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   // Timeout holds for as long as the counter sits at its limit.
   always_comb begin
      timeout = (count == LIMIT);
   end

endmodule

// File: rtl/aclk_controller.sv
// Alarm-clock control FSM: turns keypad and button activity into the
// shift/load/show strobes for the key register, alarm register, time
// counter and display mux. Moore machine; outputs depend on state only.
module aclk_controller
   import aclk_controller_pkg::*;
#(
   parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEF,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                clk,
   input  logic                reset,
   aclk_controller_if.master   bus
);

   state_t    state;
   state_t    next_state;
   ctrl_out_t outs;
   logic      timeout;
   logic      key_valid;

   always_comb begin
      key_valid = is_digit(bus.key);
   end

   aclk_timeout #(
      .TIMEOUT_SEC (TIMEOUT_SEC),
      .CNT_W       (CNT_W)
   ) u_timeout (
      .clk        (clk),
      .reset      (reset),
      .clear      (state == KEY_STORED),
      .one_second (bus.one_second),
      .timeout    (timeout)
   );

   // State register, asynchronously returned to SHOW_TIME.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= SHOW_TIME;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; unknown encodings recover to SHOW_TIME.
   always_comb begin
      next_state = SHOW_TIME;
      case (state)
         SHOW_TIME: begin
            if (bus.alarm_button)   next_state = SHOW_ALARM;
            else if (key_valid)     next_state = KEY_STORED;
            else                    next_state = SHOW_TIME;
         end
         KEY_STORED: begin
            next_state = KEY_WAITED;
         end
         KEY_WAITED: begin
            if (!key_valid)         next_state = KEY_ENTRY;
            else if (timeout)       next_state = SHOW_TIME;
            else                    next_state = KEY_WAITED;
         end
         KEY_ENTRY: begin
            if (bus.alarm_button)      next_state = SET_ALARM_TIME;
            else if (bus.time_button)  next_state = SET_CURRENT_TIME;
            else if (key_valid)        next_state = KEY_STORED;
            else if (timeout)          next_state = SHOW_TIME;
            else                       next_state = KEY_ENTRY;
         end
         SHOW_ALARM: begin
            if (bus.alarm_button)   next_state = SHOW_ALARM;
            else                    next_state = SHOW_TIME;
         end
         SET_ALARM_TIME: begin
            next_state = SHOW_TIME;
         end
         SET_CURRENT_TIME: begin
            next_state = SHOW_TIME;
         end
         default: begin
            next_state = SHOW_TIME;
         end
      endcase
   end

   // Output decode from the current state only.
   always_comb begin
      outs = '0;
      case (state)
         KEY_STORED:       outs.shift         = 1'b1;
         KEY_WAITED:       outs.show_new_time = 1'b1;
         KEY_ENTRY:        outs.show_new_time = 1'b1;
         SHOW_ALARM:       outs.show_a        = 1'b1;
         SET_ALARM_TIME:   outs.load_new_a    = 1'b1;
         SET_CURRENT_TIME: outs.load_new_c    = 1'b1;
         default:          outs               = '0;
      endcase
   end

   assign bus.shift         = outs.shift;
   assign bus.load_new_a    = outs.load_new_a;
   assign bus.load_new_c    = outs.load_new_c;
   assign bus.show_new_time = outs.show_new_time;
   assign bus.show_a        = outs.show_a;

endmodule

// File: tb/tb_aclk_controller.sv
// Self-checking bench for aclk_controller: directed scenarios followed by
// randomized keypad/button/second activity against a behavioural model.
module tb_aclk_controller;

   localparam int TSEC = 10;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   aclk_controller_if bus ();

   aclk_controller #(
      .TIMEOUT_SEC (TSEC),
      .CNT_W       (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model: mode 0 = clock shown, 1 = alarm shown, 2 = entering
   // digits. strobe: 0 none, 1 capture key, 2 commit alarm, 3 commit time.
   int m_mode;
   int m_strobe;
   int m_held;
   int m_secs;

   // Observation counters used by directed scenarios.
   int n_shift;
   int n_load_a;
   int n_load_c;
   int n_drop;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_strobe = 0;
      m_held   = 0;
      m_secs   = 0;
   endtask

   task automatic model_step();
      bit valid;
      bit tmo;
      int nsecs;
      valid = (bus.key <= 4'd9);
      tmo   = (m_secs == TSEC);
      if (m_mode == 2 && m_strobe == 1)               nsecs = 0;
      else if (bus.one_second && m_secs < TSEC)       nsecs = m_secs + 1;
      else                                            nsecs = m_secs;

      if (m_strobe == 1) begin
         m_strobe = 0;
         m_held   = 1;
      end else if (m_strobe != 0) begin
         m_strobe = 0;
         m_mode   = 0;
      end else if (m_mode == 0) begin
         if (bus.alarm_button) m_mode = 1;
         else if (valid) begin
            m_mode   = 2;
            m_strobe = 1;
         end
      end else if (m_mode == 1) begin
         if (!bus.alarm_button) m_mode = 0;
      end else if (m_held != 0) begin
         if (!valid) m_held = 0;
         else if (tmo) begin
            m_mode = 0;
            m_held = 0;
         end
      end else begin
         if (bus.alarm_button)      m_strobe = 2;
         else if (bus.time_button)  m_strobe = 3;
         else if (valid)            m_strobe = 1;
         else if (tmo)              m_mode   = 0;
      end
      m_secs = nsecs;
   endtask

   function automatic logic [4:0] expected_outs();
      return {m_strobe == 1, m_strobe == 2, m_strobe == 3,
              (m_mode == 2 && m_strobe == 0), m_mode == 1};
   endfunction

   function automatic logic [4:0] actual_outs();
      return {bus.shift, bus.load_new_a, bus.load_new_c, bus.show_new_time, bus.show_a};
   endfunction

   // One clock: advance model at the edge, compare just after, return at negedge.
   task automatic tick(input string tag);
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step();
      #1;
      check(tag, 32'(actual_outs()), 32'(expected_outs()));
      if (bus.shift)      n_shift++;
      if (bus.load_new_a) n_load_a++;
      if (bus.load_new_c) n_load_c++;
      if (!bus.show_new_time && !bus.shift) n_drop++;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.key          = 4'hA;
      bus.alarm_button = 1'b0;
      bus.time_button  = 1'b0;
      bus.one_second   = 1'b0;
   endtask

   task automatic clear_counts();
      n_shift  = 0;
      n_load_a = 0;
      n_load_c = 0;
      n_drop   = 0;
   endtask

   task automatic enter_digit(input logic [3:0] d, input string tag);
      bus.key = d;
      tick(tag);
      tick(tag);
      bus.key = 4'hA;
      tick(tag);
   endtask

   initial begin
      model_reset();
      clear_counts();
      reset            = 1'b0;
      bus.key          = 4'd5;
      bus.alarm_button = 1'b1;
      bus.time_button  = 1'b1;
      bus.one_second   = 1'b0;
      @(negedge clk);

      // Reset held with busy inputs, then released to idle.
      for (int i = 0; i < 3; i++) tick("rst_hold");
      idle_inputs();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) tick("rst_release");
      check("rst_outs_zero", 32'(actual_outs()), 32'd0);

      // Four digits each held several cycles, then commit as current time.
      clear_counts();
      for (int d = 1; d <= 4; d++) begin
         bus.key = 4'(d);
         for (int i = 0; i < 5; i++) tick("digits");
         bus.key = 4'hA;
         tick("digits");
         tick("digits");
      end
      check("t2_shift_count", 32'(n_shift), 32'd4);
      bus.time_button = 1'b1;
      tick("t2_commit");
      check("t2_load_c", 32'(actual_outs()), 32'b00100);
      bus.time_button = 1'b0;
      tick("t2_after");
      check("t2_idle", 32'(actual_outs()), 32'd0);
      check("t2_load_c_count", 32'(n_load_c), 32'd1);

      // Inactivity timeout: 9 seconds stay, the 10th abandons entry.
      enter_digit(4'd7, "t3_enter");
      for (int p = 0; p < 9; p++) begin
         bus.one_second = 1'b1;
         tick("t3_pulse");
         bus.one_second = 1'b0;
         tick("t3_gap");
      end
      check("t3_no_early_timeout", 32'(bus.show_new_time), 32'd1);
      bus.one_second = 1'b1;
      tick("t3_tenth");
      check("t3_still_entry", 32'(bus.show_new_time), 32'd1);
      bus.one_second = 1'b0;
      tick("t3_drop");
      check("t3_dropped", 32'(bus.show_new_time), 32'd0);

      // Both buttons together in entry: alarm commit wins.
      enter_digit(4'd4, "t4_enter");
      bus.alarm_button = 1'b1;
      bus.time_button  = 1'b1;
      tick("t4_both");
      check("t4_load_a_only", 32'(actual_outs()), 32'b01000);
      idle_inputs();
      tick("t4_after");
      tick("t4_after");

      // Alarm display with a key pressed: key ignored.
      clear_counts();
      bus.alarm_button = 1'b1;
      bus.key          = 4'd3;
      for (int i = 0; i < 20; i++) tick("t5_hold");
      check("t5_show_a", 32'(bus.show_a), 32'd1);
      check("t5_no_shift", 32'(n_shift), 32'd0);
      idle_inputs();
      tick("t5_release");
      check("t5_show_a_off", 32'(bus.show_a), 32'd0);

      // Key held past the timeout leaves the wait-for-release state.
      clear_counts();
      bus.key = 4'd2;
      tick("t6_press");
      n_drop = 0;
      for (int i = 0; i < 24; i++) begin
         bus.one_second = (i % 2 == 0);
         tick("t6_hold");
      end
      check("t6_exit_seen", 32'(n_drop > 0), 32'd1);
      idle_inputs();
      for (int i = 0; i < 4; i++) tick("t6_release");

      // Asynchronous reset in the middle of an alarm-commit strobe.
      enter_digit(4'd6, "t6b_enter");
      bus.alarm_button = 1'b1;
      tick("t6b_set_alarm");
      check("t6b_load_a_on", 32'(bus.load_new_a), 32'd1);
      bus.alarm_button = 1'b0;
      #1 reset = 1'b0;
      #1;
      model_reset();
      check("t6b_async_clear", 32'(actual_outs()), 32'd0);
      @(negedge clk);
      tick("t6b_in_reset");
      reset = 1'b1;
      tick("t6b_released");

      // Randomized activity with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.key          = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hA;
         bus.alarm_button = ($urandom_range(0, 19) == 0);
         bus.time_button  = ($urandom_range(0, 19) == 0);
         bus.one_second   = ($urandom_range(0, 3) == 0);
         reset            = ($urandom_range(0, 499) != 0);
         tick("rand");
      end
      reset = 1'b1;
      idle_inputs();
      tick("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
